// File: rtl/err_log_pkg.sv
// rtl/err_log_pkg.sv - shared widths, error entry type and saturating increment
package err_log_pkg;

   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 64;
   localparam int STAMP_W   = 16;
   localparam int CNT_W     = 16;
   localparam int DEF_DEPTH = 16;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  data;
      logic [STAMP_W-1:0] stamp;
   } err_entry_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/err_log_mem.sv
// rtl/err_log_mem.sv - entry storage array, one write port and one async read port
module err_log_mem
   import err_log_pkg::*;
#(
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  err_entry_t    wr_entry_i,
   input  logic [AW-1:0] rd_addr_i,
   output err_entry_t    rd_entry_o
);

   err_entry_t mem_q [DEPTH];

   always_ff @(posedge CLK) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_entry_i;
      end
   end

   assign rd_entry_o = mem_q[rd_addr_i];

endmodule

// File: rtl/err_log_fifo.sv
// rtl/err_log_fifo.sv - timestamped error event FIFO with FWFT head register and saturating counters
module err_log_fifo
   import err_log_pkg::*;
#(
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               clear,
   input  logic               error_flag,
   input  logic [ADDR_W-1:0]  error_address,
   input  logic [DATA_W-1:0]  error_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_address,
   output logic [DATA_W-1:0]  out_data,
   output logic [STAMP_W-1:0] out_stamp,
   output logic               fifo_full,
   output logic [LW-1:0]      fifo_level,
   output logic [CNT_W-1:0]   err_count,
   output logic [CNT_W-1:0]   drop_count,
   output logic               overflow
);

   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   err_entry_t         head_q, head_d;
   logic               valid_q, valid_d;
   logic [STAMP_W-1:0] stamp_q;
   logic [CNT_W-1:0]   err_q, err_d, drop_q, drop_d;
   logic               ovf_q, ovf_d;
   logic               push, pop, push_ok;
   err_entry_t         new_entry, rd_entry;

   assign push      = error_flag & ~clear;
   assign pop       = valid_q & out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push_ok   = push & ((level_q != LW'(DEPTH)) | pop);
   assign new_entry = '{addr: error_address, data: error_data, stamp: stamp_q};

   err_log_mem #(.DEPTH(DEPTH)) u_mem (
      .CLK        (CLK),
      .wr_en_i    (push_ok),
      .wr_addr_i  (wr_ptr_q),
      .wr_entry_i (new_entry),
      .rd_addr_i  (rd_ptr_d),
      .rd_entry_o (rd_entry)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      err_d    = err_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         err_d    = '0;
         drop_d   = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(push_ok) - LW'(pop);
         if (push) err_d = sat_inc(err_q);
         if (push && !push_ok) begin
            drop_d = sat_inc(drop_q);
            ovf_d  = 1'b1;
         end
      end
      valid_d = (level_d != '0);
      // The slot being written this cycle is not yet visible on the async read port.
      if (!valid_d)
         head_d = '0;
      else if (push_ok && (wr_ptr_q == rd_ptr_d))
         head_d = new_entry;
      else
         head_d = rd_entry;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         stamp_q  <= '0;
         err_q    <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
         stamp_q  <= stamp_q + STAMP_W'(1);
         err_q    <= err_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_address = head_q.addr;
   assign out_data    = head_q.data;
   assign out_stamp   = head_q.stamp;
   assign fifo_full   = (level_q == LW'(DEPTH));
   assign fifo_level  = level_q;
   assign err_count   = err_q;
   assign drop_count  = drop_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_err_log_fifo.sv
// tb/tb_err_log_fifo.sv - directed self-checking bench for err_log_fifo
module tb_err_log_fifo;
   import err_log_pkg::*;

   logic               CLK = 1'b0;
   logic               RST, clear, error_flag, out_ready;
   logic [ADDR_W-1:0]  error_address, out_address;
   logic [DATA_W-1:0]  error_data, out_data;
   logic [STAMP_W-1:0] out_stamp;
   logic               out_valid, fifo_full, overflow;
   logic [4:0]         fifo_level;
   logic [CNT_W-1:0]   err_count, drop_count;

   logic [15:0] tb_stamp;
   int checks   = 0;
   int failures = 0;

   err_log_fifo dut (
      .CLK           (CLK),
      .RST           (RST),
      .clear         (clear),
      .error_flag    (error_flag),
      .error_address (error_address),
      .error_data    (error_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_address   (out_address),
      .out_data      (out_data),
      .out_stamp     (out_stamp),
      .fifo_full     (fifo_full),
      .fifo_level    (fifo_level),
      .err_count     (err_count),
      .drop_count    (drop_count),
      .overflow      (overflow)
   );

   always #5 CLK = ~CLK;

   // Bench-side cycle counter: value of the design's timestamp in the current cycle.
   always @(posedge CLK) tb_stamp <= RST ? 16'h0 : tb_stamp + 16'h1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] exp_a;
      logic [15:0]       s0;
      int                n;

      RST = 1'b1; clear = 1'b0; out_ready = 1'b0;
      error_flag = 1'b1; error_address = 14'h155; error_data = 64'h1111;
      tick(); tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_err", err_count, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_addr", out_address, 0);
      chk("rst_data", out_data, 0);
      chk("rst_stamp", out_stamp, 0);
      RST = 1'b0; error_flag = 1'b0;
      tick();
      chk("rst_level_after", fifo_level, 0);

      n = 0;
      while (tb_stamp != 16'd5 && n < 20) begin tick(); n++; end
      error_flag = 1'b1; error_address = 14'h0123; error_data = 64'hDEADBEEF_00C0FFEE;
      tick();
      error_flag = 1'b0;
      chk("single_valid", out_valid, 1);
      chk("single_addr", out_address, 14'h0123);
      chk("single_data", out_data, 64'hDEADBEEF_00C0FFEE);
      chk("single_stamp", out_stamp, 16'd5);
      tick();
      chk("single_hold", out_address, 14'h0123);
      out_ready = 1'b1;
      tick();
      chk("single_pop_valid", out_valid, 0);
      chk("single_pop_level", fifo_level, 0);
      chk("empty_addr_zero", out_address, 0);
      tick();
      chk("empty_pop_ignored", fifo_level, 0);

      out_ready = 1'b0; error_flag = 1'b1; error_address = 14'h00AA;
      tick();
      out_ready = 1'b1; error_address = 14'h00BB;
      tick();
      out_ready = 1'b0; error_flag = 1'b0;
      chk("l1_pushpop_valid", out_valid, 1);
      chk("l1_pushpop_addr", out_address, 14'h00BB);
      chk("l1_pushpop_level", fifo_level, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      clear = 1'b1;
      tick();
      clear = 1'b0;
      error_flag = 1'b1;
      for (int i = 0; i < 19; i++) begin
         error_address = ADDR_W'(i); error_data = 64'(i);
         tick();
      end
      error_flag = 1'b0;
      chk("fill_full", fifo_full, 1);
      chk("fill_level", fifo_level, 16);
      chk("fill_drop", drop_count, 3);
      chk("fill_err", err_count, 19);
      chk("fill_ovf", overflow, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_addr", out_address, 64'(i));
         tick();
      end
      out_ready = 1'b0;
      chk("drain_level", fifo_level, 0);
      chk("drain_valid", out_valid, 0);

      error_flag = 1'b1;
      for (int i = 0; i < 16; i++) begin
         error_address = ADDR_W'(14'h20 + i);
         tick();
      end
      out_ready = 1'b1; error_address = 14'h3FFF;
      tick();
      error_flag = 1'b0;
      chk("fullpp_level", fifo_level, 16);
      chk("fullpp_drop", drop_count, 3);
      chk("fullpp_full", fifo_full, 1);
      for (int i = 0; i < 16; i++) begin
         exp_a = (i < 15) ? ADDR_W'(14'h21 + i) : 14'h3FFF;
         chk("fullpp_drain", out_address, exp_a);
         tick();
      end
      out_ready = 1'b0;

      error_flag = 1'b1;
      for (int i = 0; i < 5; i++) begin
         error_address = ADDR_W'(14'h40 + i);
         tick();
      end
      chk("clr_pre_level", fifo_level, 5);
      chk("clr_pre_ovf", overflow, 1);
      clear = 1'b1; error_address = 14'h3ABC;
      tick();
      clear = 1'b0; error_flag = 1'b0;
      chk("clr_level", fifo_level, 0);
      chk("clr_valid", out_valid, 0);
      chk("clr_err", err_count, 0);
      chk("clr_drop", drop_count, 0);
      chk("clr_ovf", overflow, 0);
      tick();
      chk("clr_absent", fifo_level, 0);

      s0 = tb_stamp;
      error_flag = 1'b1;
      for (int i = 0; i < 16; i++) begin
         error_address = ADDR_W'(14'h100 + i);
         tick();
      end
      error_address = 14'h0AAA;
      n = 0;
      while (tb_stamp != 16'hFFFE && n < 70000) begin tick(); n++; end
      chk("wrap_reach_fffe", tb_stamp, 16'hFFFE);
      out_ready = 1'b1;
      error_address = 14'h2FFE; tick();
      error_address = 14'h2FFF; tick();
      error_address = 14'h2000; tick();
      out_ready = 1'b0; error_address = 14'h0AAA;
      repeat (int'(s0) + 40) tick();
      chk("sat_drop", drop_count, 16'hFFFF);
      chk("sat_err", err_count, 16'hFFFF);
      tick();
      error_flag = 1'b0;
      chk("sat_drop_hold", drop_count, 16'hFFFF);
      chk("sat_ovf", overflow, 1);
      chk("sat_level", fifo_level, 16);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i < 13) begin
            chk("wrap_drain_addr", out_address, ADDR_W'(14'h103 + i));
         end else if (i == 13) begin
            chk("wrap_addr_fffe", out_address, 14'h2FFE);
            chk("wrap_stamp_fffe", out_stamp, 16'hFFFE);
         end else if (i == 14) begin
            chk("wrap_addr_ffff", out_address, 14'h2FFF);
            chk("wrap_stamp_ffff", out_stamp, 16'hFFFF);
         end else begin
            chk("wrap_addr_0000", out_address, 14'h2000);
            chk("wrap_stamp_0000", out_stamp, 16'h0000);
         end
         tick();
      end
      out_ready = 1'b0;
      chk("wrap_final_level", fifo_level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
